// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/write-back bundle between the issue stage and muldiv_unit
//
// Purpose: groups the operand request signals and the write-back signals of
// the iterative multiply/divide unit.
// Ports (as interface members):
//   start_in, op_in[2:0], rs1_data_in[W-1:0], rs2_data_in[W-1:0], rd_in[4:0],
//   flush_in                       - driven by the requester (master)
//   busy_out, done_out, write_en_out, rd_out[4:0], result_out[W-1:0]
//                                  - driven by the unit (slave)
interface muldiv_unit_if #(
  parameter int REG_DATA_WIDTH_POW = 6
);
  localparam int W = 1 << REG_DATA_WIDTH_POW;

  logic         start_in;
  logic [2:0]   op_in;
  logic [W-1:0] rs1_data_in;
  logic [W-1:0] rs2_data_in;
  logic [4:0]   rd_in;
  logic         flush_in;
  logic         busy_out;
  logic         done_out;
  logic         write_en_out;
  logic [4:0]   rd_out;
  logic [W-1:0] result_out;

  modport master (
    output start_in, op_in, rs1_data_in, rs2_data_in, rd_in, flush_in,
    input  busy_out, done_out, write_en_out, rd_out, result_out
  );

  modport slave (
    input  start_in, op_in, rs1_data_in, rs2_data_in, rd_in, flush_in,
    output busy_out, done_out, write_en_out, rd_out, result_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide unit, one bit per cycle
//
// Purpose: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a shift-add
// multiplier (LSB first) and a restoring divider (MSB first), W steps each.
// Ports:
//   clk_in   - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - muldiv_unit_if slave: request in, write-back out
module muldiv_unit #(
  parameter int REG_DATA_WIDTH_POW = 6
) (
  input  logic          clk_in,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);
  localparam int W = 1 << REG_DATA_WIDTH_POW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [REG_DATA_WIDTH_POW-1:0] CNT_LAST = {REG_DATA_WIDTH_POW{1'b1}};
  localparam logic [W-1:0] SIGNED_MIN = {1'b1, {(W-1){1'b0}}};

  logic [1:0]                    state_q, state_d;
  logic [2:0]                    op_q, op_d;
  logic [4:0]                    rd_q, rd_d;
  logic [REG_DATA_WIDTH_POW-1:0] cnt_q, cnt_d;
  logic                          neg_q, neg_d;
  logic                          rem_neg_q, rem_neg_d;
  logic [W-1:0]                  opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*W-1:0]                acc_q, acc_d;     // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}
  logic [W-1:0]                  result_q, result_d;

  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] abs_a, abs_b;
  logic         div_zero, div_ovf;
  logic [W:0]   mul_sum;
  logic [2*W-1:0] mul_next, mul_final;
  logic [W:0]   div_trial;
  logic         div_fit;
  logic [W-1:0] div_rem;
  logic [2*W-1:0] div_next;
  logic [W-1:0] quot_final, rem_final;

  always_comb begin
    // MULHSU: only rs1 is signed; MUL is treated as signed (low half is sign-agnostic).
    a_signed = (bus.op_in == 3'd0) || (bus.op_in == 3'd1) || (bus.op_in == 3'd2) ||
               (bus.op_in == 3'd4) || (bus.op_in == 3'd6);
    b_signed = (bus.op_in == 3'd0) || (bus.op_in == 3'd1) ||
               (bus.op_in == 3'd4) || (bus.op_in == 3'd6);
    a_neg    = a_signed && bus.rs1_data_in[W-1];
    b_neg    = b_signed && bus.rs2_data_in[W-1];
    abs_a    = a_neg ? -bus.rs1_data_in : bus.rs1_data_in;
    abs_b    = b_neg ? -bus.rs2_data_in : bus.rs2_data_in;
    div_zero = (bus.rs2_data_in == '0);
    div_ovf  = !bus.op_in[0] && (bus.rs1_data_in == SIGNED_MIN) && (bus.rs2_data_in == '1);

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc_q[W-1:1]};
    mul_final = neg_q ? -mul_next : mul_next;

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The difference is < divisor, so W bits suffice.
    div_trial  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_fit    = (div_trial >= {1'b0, opnd_q});
    div_rem    = div_fit ? (div_trial[W-1:0] - opnd_q) : div_trial[W-1:0];
    div_next   = {div_rem, acc_q[W-2:0], div_fit};
    quot_final = neg_q ? -div_next[W-1:0] : div_next[W-1:0];
    rem_final  = rem_neg_q ? -div_next[2*W-1:W] : div_next[2*W-1:W];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_in && !bus.flush_in) begin
          op_d      = bus.op_in;
          rd_d      = bus.rd_in;
          cnt_d     = '0;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          if (!bus.op_in[2]) begin
            opnd_d  = abs_a;
            acc_d   = {{W{1'b0}}, abs_b};
            state_d = S_MUL;
          end else if (div_zero || div_ovf) begin
            // op_in[1] selects remainder over quotient.
            if (bus.op_in[1]) result_d = div_zero ? bus.rs1_data_in : '0;
            else              result_d = div_zero ? '1 : bus.rs1_data_in;
            state_d = S_DONE;
          end else begin
            opnd_d  = abs_b;
            acc_d   = {{W{1'b0}}, abs_a};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (bus.flush_in) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            acc_d    = mul_final;
            result_d = (op_q == 3'd0) ? mul_final[W-1:0] : mul_final[2*W-1:W];
            state_d  = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (bus.flush_in) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d = op_q[1] ? rem_final : quot_final;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  // A flush in the DONE cycle cancels the write-back combinationally.
  assign bus.busy_out     = (state_q != S_IDLE);
  assign bus.done_out     = (state_q == S_DONE) && !bus.flush_in;
  assign bus.write_en_out = bus.done_out && (rd_q != 5'd0);
  assign bus.rd_out       = rd_q;
  assign bus.result_out   = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;
  localparam int P = 6;
  localparam int W = 64;
  localparam logic [63:0] MIN_V = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  muldiv_unit_if #(.REG_DATA_WIDTH_POW(P)) bus();
  muldiv_unit #(.REG_DATA_WIDTH_POW(P)) dut (.clk_in(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  rd;
    int          accept_cyc;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] xa, xb, p;
    logic signed [63:0] sa, sb;
    logic [63:0] r;
    sa = a; sb = b;
    xa = {{64{a[63]}}, a};
    xb = {{64{b[63]}}, b};
    r = '0;
    case (op)
      3'd0: r = a * b;
      3'd1: begin p = xa * xb; r = p[127:64]; end
      3'd2: begin p = xa * {64'd0, b}; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      3'd4: if (b == 0) r = '1; else if (a == MIN_V && b == '1) r = a; else r = sa / sb;
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) r = a; else if (a == MIN_V && b == '1) r = '0; else r = sa % sb;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == MIN_V && b == '1));
  endfunction

  // Called just after a rising edge; leaves just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input bit track, input string name);
    int guard = 0;
    while (bus.busy_out && guard < 200) begin @(posedge clk); #1; guard++; end
    if (bus.busy_out) check({"issue_wait_", name}, 64'd1, 64'd0);
    bus.start_in    = 1'b1;
    bus.op_in       = op;
    bus.rs1_data_in = a;
    bus.rs2_data_in = b;
    bus.rd_in       = rd;
    if (track) sb_q.push_back('{ref_model(op, a, b), rd, cyc + 1, is_special(op, a, b) ? 0 : W, name});
    @(posedge clk); #1;
    bus.start_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (bus.busy_out && guard < 200) begin @(posedge clk); #1; guard++; end
    if (bus.busy_out) check({"wait_idle_", name}, 64'd1, 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.done_out) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({"result_", e.name}, bus.result_out, e.result);
        check({"rd_", e.name}, {59'd0, bus.rd_out}, {59'd0, e.rd});
        check({"wen_", e.name}, {63'd0, bus.write_en_out}, {63'd0, e.rd != 5'd0});
        check({"latency_", e.name}, 64'(cyc - e.accept_cyc), 64'(e.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.start_in = 1'b0; bus.op_in = '0; bus.rs1_data_in = '0;
    bus.rs2_data_in = '0; bus.rd_in = '0; bus.flush_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", {63'd0, bus.busy_out}, 64'd0);
    check("rst_done", {63'd0, bus.done_out}, 64'd0);
    check("rst_wen", {63'd0, bus.write_en_out}, 64'd0);
    check("rst_result", bus.result_out, 64'd0);
    check("rst_rd", {59'd0, bus.rd_out}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 64'd7, -64'd3, 5'd5, 1'b1, "mul_7x-3");
    issue(3'd1, MIN_V, MIN_V, 5'd6, 1'b1, "mulh_min");
    issue(3'd3, MIN_V, MIN_V, 5'd7, 1'b1, "mulhu_min");
    issue(3'd2, '1, 64'd2, 5'd8, 1'b1, "mulhsu");
    issue(3'd4, -64'd20, 64'd6, 5'd9, 1'b1, "div_-20_6");
    issue(3'd6, -64'd20, 64'd6, 5'd10, 1'b1, "rem_-20_6");
    issue(3'd5, 64'd20, 64'd6, 5'd11, 1'b1, "divu_20_6");
    issue(3'd7, 64'd20, 64'd6, 5'd12, 1'b1, "remu_20_6");
    issue(3'd4, 64'd42, 64'd0, 5'd13, 1'b1, "div_by0");
    issue(3'd6, 64'd42, 64'd0, 5'd14, 1'b1, "rem_by0");
    issue(3'd4, MIN_V, '1, 5'd15, 1'b1, "div_ovf");
    issue(3'd6, MIN_V, '1, 5'd16, 1'b1, "rem_ovf");
    issue(3'd0, 64'd3, 64'd4, 5'd0, 1'b1, "mul_rd0");
    wait_idle("directed");

    // Flush in the middle of a divide.
    issue(3'd4, 64'd1000, 64'd7, 5'd4, 1'b0, "div_flush");
    repeat (29) @(posedge clk);
    #1 bus.flush_in = 1'b1;
    @(posedge clk); #1;
    bus.flush_in = 1'b0;
    check("flush_busy", {63'd0, bus.busy_out}, 64'd0);
    check("flush_done", {63'd0, bus.done_out}, 64'd0);
    issue(3'd0, 64'd11, 64'd13, 5'd3, 1'b1, "mul_after_flush");

    // Starts while busy must be dropped.
    repeat (5) begin
      bus.start_in = 1'b1; bus.op_in = 3'd4; bus.rs1_data_in = 64'd99;
      bus.rs2_data_in = 64'd0; bus.rd_in = 5'd21;
      @(posedge clk); #1;
    end
    bus.start_in = 1'b0;
    wait_idle("busy_drop");

    // Flush in IDLE blocks acceptance.
    bus.start_in = 1'b1; bus.flush_in = 1'b1; bus.op_in = 3'd5;
    bus.rs1_data_in = 64'd9; bus.rs2_data_in = 64'd0; bus.rd_in = 5'd2;
    @(posedge clk); #1;
    bus.start_in = 1'b0; bus.flush_in = 1'b0;
    check("idle_flush_busy", {63'd0, bus.busy_out}, 64'd0);

    // Flush during the DONE cycle suppresses the write-back.
    issue(3'd5, 64'd100, 64'd7, 5'd3, 1'b0, "divu_done_flush");
    repeat (W) @(posedge clk);
    #1 bus.flush_in = 1'b1;
    #1;
    check("done_flush_busy", {63'd0, bus.busy_out}, 64'd1);
    check("done_flush_done", {63'd0, bus.done_out}, 64'd0);
    check("done_flush_wen", {63'd0, bus.write_en_out}, 64'd0);
    @(posedge clk); #1;
    bus.flush_in = 1'b0;

    // Asynchronous reset in the middle of a multiply.
    issue(3'd0, 64'd123, 64'd456, 5'd17, 1'b0, "mul_reset");
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, bus.busy_out}, 64'd0);
    check("arst_done", {63'd0, bus.done_out}, 64'd0);
    check("arst_wen", {63'd0, bus.write_en_out}, 64'd0);
    check("arst_result", bus.result_out, 64'd0);
    check("arst_rd", {59'd0, bus.rd_out}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("arst_idle", {63'd0, bus.busy_out}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [63:0] a, b;
      int mode;
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = $urandom_range(0, 9);
      if (mode == 0) b = '0;
      else if (mode == 1) begin a = MIN_V; b = '1; end
      else if (mode == 2) begin
        a = 64'($signed(32'($urandom_range(0, 2000)) - 32'sd1000));
        b = 64'($signed(32'($urandom_range(0, 60)) - 32'sd30));
      end
      issue(op, a, b, 5'($urandom_range(0, 31)), 1'b1, $sformatf("rand%0d_op%0d", i, op));
    end

    begin
      int guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
